// File: rtl/rr_grant_if.sv
// Request/grant bundle between the requesters and the rotating-priority
// grant scheduler.
//   en        : arbitration enable (0 = no new grants, no preemption)
//   req       : request vector, bit i = requester i wants the resource
//   gnt       : registered one-hot grant
//   gnt_id    : index of the set gnt bit, 0 when nothing is granted
//   gnt_valid : 1 when gnt holds exactly one bit
//   preempt   : one-cycle pulse when the hold limit moved the grant
// master = requester side, slave = scheduler side.
interface rr_grant_if #(
  parameter int NREQ = 8,
  parameter int IDW  = 3
);
  logic            en;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_valid;
  logic            preempt;

  modport master (
    output en, req,
    input  gnt, gnt_id, gnt_valid, preempt
  );

  modport slave (
    input  en, req,
    output gnt, gnt_id, gnt_valid, preempt
  );
endinterface

// File: rtl/rr_grant_scheduler.sv
// Rotating-priority grant scheduler sharing one downstream resource between
// 8 requesters. The search runs from ptr-1 downwards (wrapping 0->7) and
// ends at ptr itself, where ptr is the last winner. The grant is registered
// and held while the owner keeps its request; an optional hold limit forces
// the grant onward when others are waiting.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (wins over every other input)
//   bus : rr_grant_if.slave (en, req in; gnt, gnt_id, gnt_valid, preempt out)
module rr_grant_scheduler #(
  parameter int NREQ       = 8,
  parameter int IDW        = 3,
  parameter int MAX_HOLD   = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic      clk,
  input  logic      rst,
  rr_grant_if.slave bus
);

  // Counter wide enough for MAX_HOLD; with MAX_HOLD=0 it just saturates
  // at 1 and never triggers the limit.
  localparam int HW   = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int HSAT = (MAX_HOLD == 0) ? 1 : MAX_HOLD;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nxt;
  logic [NREQ-1:0] gnt_r, gnt_nxt;
  logic [IDW-1:0]  ptr_r, ptr_nxt;
  logic [HW-1:0]   hold_r, hold_nxt;
  logic            pre_r, pre_nxt;

  logic [NREQ-1:0] others;
  logic [IDW-1:0]  start;
  logic [IDW-1:0]  owner;
  logic [IDW-1:0]  win;
  logic            limit;

  // First set bit in the order start-1, start-2, ..., start (mod NREQ).
  function automatic logic [IDW-1:0] search(input logic [NREQ-1:0] elig,
                                            input logic [IDW-1:0]  from);
    logic [IDW-1:0] idx;
    logic [IDW-1:0] res;
    logic           found;
    res   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = from - IDW'(k);
      if (!found && elig[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [IDW-1:0] encode(input logic [NREQ-1:0] oh);
    logic [IDW-1:0] res;
    res = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) res = IDW'(i);
    end
    return res;
  endfunction

  // In IDLE gnt_r is zero, so "others" is the whole request vector and one
  // search serves both the first grant and every hand-over.
  assign others = bus.req & ~gnt_r;
  assign start  = (FIXED_PRIO != 0) ? '0 : ptr_r;
  assign owner  = encode(gnt_r);
  assign win    = search(others, start);
  assign limit  = (MAX_HOLD != 0) && (hold_r == HW'(HSAT)) && (|others) && bus.en;

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_r;
    ptr_nxt   = ptr_r;
    hold_nxt  = hold_r;
    pre_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.en && (|bus.req)) begin
          state_nxt = GRANT;
          gnt_nxt   = NREQ'(1) << win;
          ptr_nxt   = (FIXED_PRIO != 0) ? '0 : win;
          hold_nxt  = HW'(1);
        end else begin
          gnt_nxt  = '0;
          hold_nxt = '0;
        end
      end
      GRANT: begin
        if (!bus.req[owner]) begin
          // Release: hand over without a bubble, or drop to IDLE keeping ptr.
          if (bus.en && (|others)) begin
            gnt_nxt  = NREQ'(1) << win;
            ptr_nxt  = (FIXED_PRIO != 0) ? '0 : win;
            hold_nxt = HW'(1);
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            hold_nxt  = '0;
          end
        end else if (limit) begin
          gnt_nxt  = NREQ'(1) << win;
          ptr_nxt  = (FIXED_PRIO != 0) ? '0 : win;
          hold_nxt = HW'(1);
          pre_nxt  = 1'b1;
        end else if (hold_r != HW'(HSAT)) begin
          hold_nxt = hold_r + HW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt_r  <= '0;
      ptr_r  <= '0;
      hold_r <= '0;
      pre_r  <= 1'b0;
    end else begin
      state  <= state_nxt;
      gnt_r  <= gnt_nxt;
      ptr_r  <= ptr_nxt;
      hold_r <= hold_nxt;
      pre_r  <= pre_nxt;
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.gnt_id    = owner;
  assign bus.gnt_valid = |gnt_r;
  assign bus.preempt   = pre_r;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed bench for rr_grant_scheduler: one instance with MAX_HOLD=4
// (rotating) and one with FIXED_PRIO=1.
module tb_rr_grant_scheduler;

  logic clk;
  logic rst;

  rr_grant_if bus_a ();
  rr_grant_if bus_b ();

  rr_grant_scheduler #(.MAX_HOLD(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  rr_grant_scheduler #(.FIXED_PRIO(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] enc8(input logic [7:0] oh);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (oh[i]) r = 3'(i);
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [7:0] eg, input logic ep);
    chk({tag, "_gnt"},   32'(bus_a.gnt),       32'(eg));
    chk({tag, "_id"},    32'(bus_a.gnt_id),    32'(enc8(eg)));
    chk({tag, "_vld"},   32'(bus_a.gnt_valid), 32'(|eg));
    chk({tag, "_pre"},   32'(bus_a.preempt),   32'(ep));
  endtask

  task automatic chk_b(input string tag, input logic [7:0] eg);
    chk({tag, "_gnt"}, 32'(bus_b.gnt),    32'(eg));
    chk({tag, "_id"},  32'(bus_b.gnt_id), 32'(enc8(eg)));
  endtask

  logic [7:0] rot_exp [8] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
  logic [7:0] cur;

  initial begin
    rst = 1'b1;
    bus_a.en = 1'b1; bus_a.req = 8'h00;
    bus_b.en = 1'b1; bus_b.req = 8'h00;
    cyc(); cyc();
    rst = 1'b0;
    chk_a("reset", 8'h00, 1'b0);
    chk_b("reset_b", 8'h00);

    // 1: first grant, then bubble-free hand-over on release
    bus_a.req = 8'h81; cyc(); chk_a("t1_first", 8'h80, 1'b0);
    bus_a.req = 8'h01; cyc(); chk_a("t1_handover", 8'h01, 1'b0);
    bus_a.req = 8'h00; cyc(); chk_a("t1_idle", 8'h00, 1'b0);

    // 2: rotation with all requesting; owner drops its bit for one cycle
    bus_a.req = 8'hFF; cyc(); chk_a("t2_start", 8'h80, 1'b0);
    cur = 8'h80;
    for (int i = 0; i < 8; i++) begin
      bus_a.req = 8'hFF & ~cur;
      cyc();
      chk_a($sformatf("t2_rot%0d", i), rot_exp[i], 1'b0);
      cur = rot_exp[i];
    end
    bus_a.req = 8'h00; cyc(); chk_a("t2_idle", 8'h00, 1'b0);

    // 3a: hold limit with requester 5 waiting
    bus_a.req = 8'h08; cyc(); chk_a("t3_g1", 8'h08, 1'b0);
    bus_a.req = 8'h28;
    for (int i = 2; i <= 4; i++) begin
      cyc(); chk_a($sformatf("t3_g%0d", i), 8'h08, 1'b0);
    end
    cyc(); chk_a("t3_preempt", 8'h20, 1'b1);
    cyc(); chk_a("t3_after", 8'h20, 1'b0);
    bus_a.req = 8'h00; cyc(); chk_a("t3_idle", 8'h00, 1'b0);

    // 3b: nobody waiting -> owner 3 keeps the grant
    bus_a.req = 8'h08;
    for (int i = 0; i < 10; i++) begin
      cyc(); chk_a($sformatf("t3b_hold%0d", i), 8'h08, 1'b0);
    end
    bus_a.req = 8'h00; cyc(); chk_a("t3b_idle", 8'h00, 1'b0);

    // 4: en=0 keeps a held grant, blocks preemption and new grants
    bus_a.req = 8'h04; cyc(); chk_a("t4_grant", 8'h04, 1'b0);
    bus_a.en = 1'b0; bus_a.req = 8'h14;
    for (int i = 0; i < 6; i++) begin
      cyc(); chk_a($sformatf("t4_hold%0d", i), 8'h04, 1'b0);
    end
    bus_a.req = 8'h10;
    cyc(); chk_a("t4_release", 8'h00, 1'b0);
    cyc(); chk_a("t4_blocked", 8'h00, 1'b0);
    bus_a.en = 1'b1;
    cyc(); chk_a("t4_enable", 8'h10, 1'b0);

    // 5: reset mid-grant clears outputs and the pointer
    bus_a.req = 8'h40; cyc(); chk_a("t5_grant", 8'h40, 1'b0);
    cyc(); chk_a("t5_hold", 8'h40, 1'b0);
    rst = 1'b1; cyc(); chk_a("t5_rst", 8'h00, 1'b0);
    rst = 1'b0; bus_a.req = 8'h41; cyc(); chk_a("t5_ptr0", 8'h40, 1'b0);
    bus_a.req = 8'h00; cyc(); chk_a("t5_idle", 8'h00, 1'b0);

    // 6: fixed priority, release and re-request always picks 3
    for (int i = 0; i < 3; i++) begin
      bus_b.req = 8'h0C; cyc(); chk_b($sformatf("t6_gnt%0d", i), 8'h08);
      bus_b.req = 8'h00; cyc(); chk_b($sformatf("t6_idle%0d", i), 8'h00);
    end
    bus_b.req = 8'h0C; cyc(); chk_b("t6_again", 8'h08);
    bus_b.req = 8'h04; cyc(); chk_b("t6_handover", 8'h04);
    bus_b.req = 8'h00; cyc();
    bus_b.req = 8'h0C; cyc(); chk_b("t6_final", 8'h08);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
